// File: rtl/vending_machine_param.sv
// vending_machine_param: nickel-unit vending FSM with credit, change return and stock tracking
module vending_machine_param #(
  parameter int PRICE       = 4,
  parameter int CREDIT_W    = 4,
  parameter int STOCK_DEPTH = 8,
  parameter int STOCK_W     = $clog2(STOCK_DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                nickle_i,
  input  logic                dime_i,
  input  logic                quarter_i,
  input  logic                cancel_i,
  input  logic                restock_i,
  output logic                soda_o,
  output logic                nickel_o,
  output logic                coin_reject_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                busy_o,
  output logic                sold_out_o
);
  if (PRICE < 1 || PRICE + 4 >= 2 ** CREDIT_W) begin : g_bad_params
    $error("vending_machine_param: need PRICE >= 1 and PRICE+4 < 2**CREDIT_W");
  end
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [STOCK_W-1:0]  DEPTH_C = STOCK_W'(STOCK_DEPTH);
  state_t                state, state_n;
  logic [CREDIT_W-1:0]   credit, credit_n, owed, owed_n, value, sum;
  logic [STOCK_W-1:0]    stock, stock_n;
  logic [1:0]            coins;
  logic                  open, accept, coin_any, vend_go, cancel_go;
  always_comb begin
    coins     = {1'b0, nickle_i} + {1'b0, dime_i} + {1'b0, quarter_i};
    coin_any  = coins != 2'd0;
    value     = quarter_i ? CREDIT_W'(5) : dime_i ? CREDIT_W'(2) : CREDIT_W'(1);
    sum       = credit + value;
    open      = state == IDLE || state == COLLECT;
    accept    = coins == 2'd1 && open && stock != '0 && !cancel_i;
    vend_go   = accept && sum >= PRICE_C;
    cancel_go = cancel_i && state == COLLECT;
    state_n   = state;
    credit_n  = credit;
    owed_n    = owed;
    if (cancel_go) begin
      state_n  = CHANGE;
      owed_n   = credit;
      credit_n = '0;
    end else if (vend_go) begin
      state_n  = VEND;
      owed_n   = sum - PRICE_C;
      credit_n = '0;
    end else if (accept) begin
      state_n  = COLLECT;
      credit_n = sum;
    end else if (state == VEND) begin
      state_n = owed != '0 ? CHANGE : IDLE;
    end else if (state == CHANGE) begin
      owed_n  = owed - CREDIT_W'(1);
      state_n = owed <= CREDIT_W'(1) ? IDLE : CHANGE;
    end
    // restock overrides a same-cycle vend decrement
    stock_n = restock_i ? DEPTH_C : vend_go ? stock - STOCK_W'(1) : stock;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      credit        <= '0;
      owed          <= '0;
      stock         <= DEPTH_C;
      soda_o        <= 1'b0;
      nickel_o      <= 1'b0;
      coin_reject_o <= 1'b0;
    end else begin
      state         <= state_n;
      credit        <= credit_n;
      owed          <= owed_n;
      stock         <= stock_n;
      soda_o        <= state_n == VEND;
      nickel_o      <= state_n == CHANGE;
      coin_reject_o <= coin_any && !accept;
    end
  end
  assign credit_o   = credit;
  assign busy_o     = state == VEND || state == CHANGE;
  assign sold_out_o = stock == '0;
endmodule
